// File: rtl/edge_meter_pkg.sv
// Shared definitions for the edge period meter: FSM state encoding and
// default timing constants.
package edge_meter_pkg;

    // state   | meaning
    // IDLE    | no reference edge yet (after reset or signal loss)
    // MEASURE | at least one rising edge seen, periods being reported
    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE    = 1'b0;
    localparam state_t ST_MEASURE = 1'b1;

    // Loss-of-signal window: about 1.34 s at 100 MHz.
    localparam int unsigned DEFAULT_TIMEOUT = 2**27;
    localparam int unsigned DEFAULT_TOL     = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a delay flop,
// producing single-cycle rise/fall strobes in the clk domain.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Metastability chain (s1, s2) plus one history stage (s3) for edge compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/edge_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk
// cycles, flags loss of signal and reports period-to-period stability.
//
// state   | meaning
// IDLE    | waiting for a first rising edge; outputs hold last results
// MEASURE | each rising edge reports period/high_time; timeout watched
module edge_period_meter
    import edge_meter_pkg::*;
#(
    parameter int          W       = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned TOL     = DEFAULT_TOL
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         timeout,
    output logic         stable
);

    localparam logic [W-1:0] CNT_ONE     = W'(1);
    localparam logic [W-1:0] CNT_MAX     = '1;
    localparam logic [W-1:0] TIMEOUT_CNT = W'(TIMEOUT);
    localparam logic [W-1:0] TOL_CNT     = W'(TOL);

    logic         rise;
    logic         fall;
    logic [W-1:0] cnt;
    logic [W-1:0] hi_lat;
    logic [W-1:0] delta;
    logic         seen_valid;
    state_t       state;

    sync_edge_detect u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    // Distance between the period just measured and the one currently reported.
    always_comb begin
        delta = (cnt >= period) ? (cnt - period) : (period - cnt);
    end

    // Cycle counter restarted by each rising edge; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_ONE;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Capture elapsed count at the falling edge as the pending high time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_lat <= '0;
        end else if (fall) begin
            hi_lat <= cnt;
        end
    end

    // Sequencing FSM: result registers, valid strobe, timeout and stability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            period     <= '0;
            high_time  <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            stable     <= 1'b0;
            seen_valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state      <= ST_MEASURE;
                        timeout    <= 1'b0;
                        seen_valid <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    // A rise coinciding with the timeout count is a valid measurement.
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hi_lat;
                        valid      <= 1'b1;
                        stable     <= seen_valid && (delta <= TOL_CNT);
                        seen_valid <= 1'b1;
                    end else if (cnt == TIMEOUT_CNT) begin
                        state   <= ST_IDLE;
                        timeout <= 1'b1;
                        stable  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_period_meter.sv
// Scoreboard bench for edge_period_meter: stimulus pushes expected results
// derived from rise/fall timestamps, a monitor pops them on each valid.
module tb_edge_period_meter;

    localparam int W   = 16;
    localparam int TMO = 1000;
    localparam int TOL = 2;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;
    logic         stable;

    edge_period_meter #(.W(W), .TIMEOUT(TMO), .TOL(TOL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .stable    (stable)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int p;
        int h;
        int st;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int total = 0;
    int bad   = 0;

    // reference model state, in cycle timestamps
    bit measuring = 1'b0;
    int nvalid    = 0;
    int last_rise = 0;
    int last_high = 0;
    int prev_p    = 0;
    int last_p    = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_rise(input int t);
        int p;
        int d;
        if (measuring && (t - last_rise) <= TMO) begin
            p = t - last_rise;
            d = p - prev_p;
            if (d < 0) d = -d;
            q.push_back('{p, last_high, (nvalid > 0 && d <= TOL) ? 1 : 0});
            nvalid++;
            prev_p = p;
            last_p = p;
        end else begin
            measuring = 1'b1;
            nvalid    = 0;
        end
        last_rise = t;
    endtask

    task automatic pulse(input int h, input int l);
        sig_in = 1'b1;
        model_rise(cyc);
        wait_cyc(h);
        sig_in = 1'b0;
        last_high = cyc - last_rise;
        wait_cyc(l);
    endtask

    // monitor: every valid must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got period=%0d high_time=%0d required no valid (cycle %0d)",
                         period, high_time, cyc);
            end else begin
                e = q.pop_front();
                check("period", int'(period), e.p);
                check("high_time", int'(high_time), e.h);
                check("stable", int'(stable), e.st);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        int m;
        int base;
        int p;
        int h;

        wait_cyc(4);
        check("rst_period", int'(period), 0);
        check("rst_high_time", int'(high_time), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_stable", int'(stable), 0);
        rst_n = 1'b1;
        wait_cyc(3);

        // steady 100/40, then switch to 150
        repeat (5) pulse(40, 60);
        repeat (3) pulse(40, 110);
        // jitter inside and outside tolerance
        pulse(40, 60);
        pulse(40, 60);
        pulse(40, 62);
        pulse(40, 59);
        pulse(40, 60);
        pulse(40, 64);
        // gap of exactly TIMEOUT: rise wins
        pulse(40, 960);
        sig_in = 1'b1;
        model_rise(cyc);
        wait_cyc(5);
        check("timeout_at_limit", int'(timeout), 0);
        wait_cyc(35);
        sig_in = 1'b0;
        last_high = cyc - last_rise;
        wait_cyc(60);
        // gap one beyond TIMEOUT: lost, next rise reports nothing
        pulse(40, 961);
        pulse(40, 60);
        pulse(40, 60);

        // held low after a rise: exact timeout instant, period held
        sig_in = 1'b1;
        model_rise(cyc);
        n = cyc;
        wait_cyc(40);
        sig_in = 1'b0;
        last_high = cyc - last_rise;
        wait_cyc(n + 2 + TMO - cyc);
        check("timeout_before", int'(timeout), 0);
        wait_cyc(1);
        check("timeout_asserted", int'(timeout), 1);
        check("period_held", int'(period), last_p);
        check("stable_after_timeout", int'(stable), 0);
        wait_cyc(50);
        check("timeout_sticky", int'(timeout), 1);
        sig_in = 1'b1;
        model_rise(cyc);
        m = cyc;
        wait_cyc(2);
        check("timeout_until_rise", int'(timeout), 1);
        wait_cyc(1);
        check("timeout_cleared", int'(timeout), 0);
        wait_cyc(m + 40 - cyc);
        sig_in = 1'b0;
        last_high = cyc - last_rise;
        wait_cyc(60);
        repeat (3) pulse(30, 70);

        // randomized periods with occasional base changes and small jitter
        base = 50;
        for (int i = 0; i < 30; i++) begin
            if (i % 8 == 0) base = $urandom_range(10, 200);
            p = base + int'($urandom_range(0, 6)) - 3;
            h = $urandom_range(2, p - 2);
            pulse(h, p - h);
        end

        // reset mid-period
        sig_in = 1'b1;
        model_rise(cyc);
        wait_cyc(20);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_period", int'(period), 0);
        check("midrst_high_time", int'(high_time), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_timeout", int'(timeout), 0);
        check("midrst_stable", int'(stable), 0);
        check("midrst_pending", q.size(), 0);
        q.delete();
        measuring = 1'b0;
        sig_in = 1'b0;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(5);
        repeat (4) pulse(25, 55);

        // closing rise so the last period is reported
        sig_in = 1'b1;
        model_rise(cyc);
        wait_cyc(10);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
